line_fill_buffer: RTL and testbench
===================================

LINE_FILL_BUFFER -- requirements
Module: line_fill_buffer

Interface
REQ-001 Parameters SHALL be: BLOCK_SIZE, default 64, line size in bytes.
REQ-002 Parameters SHALL be: WORD_SIZE, default 4, memory bus word size in bytes; BEATS = BLOCK_SIZE/WORD_SIZE (16).
REQ-003 Ports SHALL be:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- ask_for_data  input  1  line-fill request from the cache.
- wb_req  input  1  dirty-line writeback request from the cache.
- address  input  32  byte address of the line to fill.
- wb_addr  input  32  byte address of the line to write back.
- wb_data  input  512  dirty line contents; word i is in bits [32i+31:32i].
- mem_ready  input  1  main memory accepts or returns the current beat.
- mem_rdata  input  32  read beat from main memory.
- mem_req  output  1  beat request to main memory.
- mem_we  output  1  1 = write beat, 0 = read beat.
- mem_addr  output  32  beat byte address.
- mem_wdata  output  32  write beat data.
- data_to_write  output  512  assembled line for the cache load (c6 path).
- fill_valid  output  1  one-cycle pulse: data_to_write is complete.
- wb_done  output  1  one-cycle pulse: writeback is finished.
- busy  output  1  high in every state except IDLE.

Function
REQ-004 The FSM SHALL have four states: IDLE, WB, FILL, DONE.
REQ-005 In IDLE, a rising edge with wb_req=1 SHALL do three things: latch wb_addr[31:6] and wb_data, clear the beat counter, and go to WB.
REQ-006 In IDLE, ask_for_data=1 SHALL latch address[31:6], clear the beat counter, and go to FILL; ask_for_data is latched even when wb_req is also high.
REQ-007 When wb_req and ask_for_data are both high in IDLE, the block SHALL run WB first; after the last write beat it SHALL go directly to FILL using the latched fill address.
REQ-008 Requests arriving while busy=1 SHALL be ignored; only the pending fill latched per REQ-007 is retained.
REQ-009 In WB and FILL, mem_req SHALL be 1 and mem_addr SHALL be {line_addr, beat[3:0], 2'b00}.
REQ-010 mem_we SHALL be 1 in WB and 0 in FILL; mem_wdata SHALL be latched line word[beat] in WB and 0 otherwise.
REQ-011 A beat SHALL be accepted only on an edge where mem_req=1 and mem_ready=1.
REQ-012 mem_addr, mem_we and mem_wdata SHALL stay stable until the beat is accepted; mem_ready while mem_req=0 SHALL be ignored.
REQ-013 On each accepted FILL beat, mem_rdata SHALL be written to data_to_write[32*beat+31:32*beat]; other words SHALL hold.
REQ-014 The beat counter is 4 bits and SHALL increment per accepted beat; accepting beat 15 wraps it to 0 and ends the phase.
REQ-015 Ending WB SHALL pulse wb_done for one cycle, then go to FILL if a fill is pending, else to IDLE.
REQ-016 Ending FILL SHALL go to DONE; DONE SHALL assert fill_valid for exactly one cycle, then return to IDLE.
REQ-017 data_to_write SHALL hold its value after DONE until the next FILL beat is accepted.
REQ-018 Latency with mem_ready tied 1: request sampled at edge N, beats accepted at edges N+1..N+16, fill_valid high between edges N+16 and N+17.
REQ-019 Latency for back-to-back WB+FILL with mem_ready tied 1: fill_valid follows 33 edges after the request.

Reset
REQ-020 rst=0 SHALL immediately set the state to IDLE, the beat counter to 0, and clear the pending-fill flag.
REQ-021 rst=0 SHALL immediately drive mem_req, mem_we, fill_valid, wb_done and busy to 0, and mem_addr, mem_wdata and data_to_write to all-zero.
REQ-022 Reset during WB or FILL SHALL abort the operation: no wb_done or fill_valid pulse, partial line discarded.
REQ-023 The first request after rst returns to 1 SHALL be sampled on the next rising edge.

Structure
REQ-024 BLOCK_SIZE, WORD_SIZE, BEATS and the 2-bit state encoding SHALL live in a shared package, cache_pkg, which is also used by Cache.
REQ-025 Line assembly (indexed 32-bit word write into a 512-bit register) SHALL be one sub-module, line_assembler; the FSM and counter SHALL stay in line_fill_buffer.

Verification
REQ-026 Fill: ask_for_data=1, address=0x0000_1234, mem_ready=1, mem_rdata=0xA000_0000+beat -> mem_addr steps 0x1200..0x123C, fill_valid at edge N+16, word i = 0xA000_0000+i.
REQ-027 Writeback: wb_req=1, wb_addr=0x0000_4000, word i of wb_data = i -> 16 write beats, mem_wdata=i at mem_addr 0x4000+4i, single wb_done pulse, no fill_valid.
REQ-028 Simultaneous wb_req+ask_for_data -> 16 writes, then 16 reads with no IDLE cycle between, wb_done then fill_valid, fill_valid at edge N+33.
REQ-029 Stall: mem_ready low for 3 cycles at beat 7 -> mem_addr/mem_we held stable, beat 7 written once, fill_valid delayed by exactly 3 cycles.
REQ-030 Reset at beat 9 of FILL -> all outputs 0 within the same cycle, no fill_valid; a new request afterwards completes normally.
REQ-031 ask_for_data pulsed while busy -> ignored, exactly one fill_valid.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache geometry and line-fill-buffer state encoding.
// Used by both the cache controller and its line fill buffer.
package cache_pkg;

    localparam int BLOCK_SIZE = 64;                      // line size in bytes
    localparam int WORD_SIZE  = 4;                       // memory bus word in bytes
    localparam int BEATS      = BLOCK_SIZE / WORD_SIZE;  // bus beats per line

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } lfb_state_t;

endpackage

// File: rtl/line_assembler.sv
// Builds a cache line one bus word at a time; words not addressed by
// the current write keep their previous contents.
module line_assembler #(
    parameter int LINE_W = 512,
    parameter int WORD_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [LINE_W-1:0] line
);

    localparam int WORDS = LINE_W / WORD_W;

    // NOTE: sequential state is always assigned with <=, so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line <= '0;
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (we && idx == IDX_W'(i)) begin
                    line[i*WORD_W +: WORD_W] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/line_fill_buffer.sv
// Line fill buffer: writes back a dirty line and/or fills a line from
// main memory one bus word per accepted beat.
module line_fill_buffer
    import cache_pkg::*;
#(
    parameter int BLOCK_SIZE = cache_pkg::BLOCK_SIZE,
    parameter int WORD_SIZE  = cache_pkg::WORD_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ask_for_data,
    input  logic                    wb_req,
    input  logic [31:0]             address,
    input  logic [31:0]             wb_addr,
    input  logic [BLOCK_SIZE*8-1:0] wb_data,
    input  logic                    mem_ready,
    input  logic [WORD_SIZE*8-1:0]  mem_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [WORD_SIZE*8-1:0]  mem_wdata,
    output logic [BLOCK_SIZE*8-1:0] data_to_write,
    output logic                    fill_valid,
    output logic                    wb_done,
    output logic                    busy
);

    localparam int LINE_W  = BLOCK_SIZE * 8;
    localparam int WORD_W  = WORD_SIZE * 8;
    localparam int N_BEATS = BLOCK_SIZE / WORD_SIZE;
    localparam int OFF_W   = $clog2(BLOCK_SIZE);
    localparam int WOFF_W  = $clog2(WORD_SIZE);
    localparam int BEAT_W  = OFF_W - WOFF_W;
    localparam int TAG_W   = 32 - OFF_W;

    lfb_state_t        state;
    lfb_state_t        next_state;
    logic [BEAT_W-1:0] beat;
    logic [TAG_W-1:0]  wb_tag;
    logic [TAG_W-1:0]  fill_tag;
    logic              fill_pend;
    logic              wb_end;
    logic [LINE_W-1:0] wb_line;

    logic take_wb;
    logic take_fill;
    logic beat_acc;
    logic last_beat;

    assign take_wb   = (state == IDLE) && wb_req;
    assign take_fill = (state == IDLE) && ask_for_data;
    assign beat_acc  = mem_req && mem_ready;
    assign last_beat = beat_acc && (beat == BEAT_W'(N_BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (wb_req) begin
                    next_state = WB;
                end else if (ask_for_data) begin
                    next_state = FILL;
                end
            end
            WB: begin
                if (wb_end) begin
                    next_state = fill_pend ? FILL : IDLE;
                end
            end
            FILL: begin
                if (last_beat) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The wb_done cycle stays in WB with the request dropped, so the
    // memory never sees a seventeenth write while the pulse is up.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            WB: begin
                mem_req   = !wb_end;
                mem_we    = 1'b1;
                mem_addr  = {wb_tag, beat, {WOFF_W{1'b0}}};
                mem_wdata = wb_line[beat*WORD_W +: WORD_W];
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {fill_tag, beat, {WOFF_W{1'b0}}};
            end
            default: ;
        endcase
    end

    assign busy       = (state != IDLE);
    assign fill_valid = (state == DONE);
    assign wb_done    = wb_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat      <= '0;
            wb_tag    <= '0;
            fill_tag  <= '0;
            fill_pend <= 1'b0;
            wb_end    <= 1'b0;
        end else begin
            wb_end <= (state == WB) && last_beat;
            if (take_wb || take_fill) begin
                beat <= '0;
            end else if (beat_acc) begin
                beat <= beat + BEAT_W'(1);
            end
            if (take_wb) begin
                wb_tag <= wb_addr[31:OFF_W];
            end
            if (take_fill) begin
                fill_tag <= address[31:OFF_W];
            end
            // A fill that arrives alongside a writeback waits for it.
            if (take_wb) begin
                fill_pend <= ask_for_data;
            end else if (wb_end) begin
                fill_pend <= 1'b0;
            end
        end
    end

    // NOTE: the writeback line buffer has no reset; it is only read in WB,
    // which is always entered through a fresh capture in IDLE.
    always_ff @(posedge clk) begin
        if (take_wb) begin
            wb_line <= wb_data;
        end
    end

    line_assembler #(
        .LINE_W (LINE_W),
        .WORD_W (WORD_W),
        .IDX_W  (BEAT_W)
    ) u_line_assembler (
        .clk   (clk),
        .rst   (rst),
        .we    (beat_acc && (state == FILL)),
        .idx   (beat),
        .wdata (mem_rdata),
        .line  (data_to_write)
    );

endmodule

// File: tb/tb_line_fill_buffer.sv
// Scoreboard bench for line_fill_buffer: a transaction-level model queues
// expected bus beats and pulses, a negedge monitor pops and compares.
module tb_line_fill_buffer;
    import cache_pkg::*;

    localparam int LINE_W = BLOCK_SIZE * 8;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        bit                is_fill;
        logic [LINE_W-1:0] line;
        int                exp_cyc;
    } event_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              ask_for_data;
    logic              wb_req;
    logic [31:0]       address;
    logic [31:0]       wb_addr;
    logic [LINE_W-1:0] wb_data;
    logic              mem_ready = 1'b1;
    logic [31:0]       mem_rdata = '0;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [LINE_W-1:0] data_to_write;
    logic              fill_valid;
    logic              wb_done;
    logic              busy;

    line_fill_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .ask_for_data  (ask_for_data),
        .wb_req        (wb_req),
        .address       (address),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .data_to_write (data_to_write),
        .fill_valid    (fill_valid),
        .wb_done       (wb_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    beat_t             exp_beats[$];
    event_t            exp_events[$];
    logic [LINE_W-1:0] model_line = '0;

    int          ready_mode = 0;
    int          stall_beat = -1;
    int          stall_left = 0;
    logic [31:0] rd_salt    = '0;

    task automatic check(input string name, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Memory contents as a pure function of the beat address.
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (rd_salt == 32'h0) return 32'hA000_0000 + {28'h0, a[5:2]};
        return (a * 32'h9E37_79B1) ^ rd_salt;
    endfunction

    always @(posedge clk) begin
        #1;
        mem_rdata = rd_val(mem_addr);
        if (mem_req && stall_left > 0 && int'(mem_addr[5:2]) == stall_beat) begin
            mem_ready = 1'b0;
            stall_left--;
        end else if (ready_mode == 1) begin
            mem_ready = ($urandom_range(0, 3) != 0);
        end else begin
            mem_ready = 1'b1;
        end
    end

    task automatic take_event(input bit is_fill);
        event_t e;
        if (exp_events.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_%s: pulse with nothing pending (cycle %0d)",
                     is_fill ? "fill_valid" : "wb_done", cyc);
            return;
        end
        e = exp_events.pop_front();
        check(is_fill ? "pulse_kind_fill" : "pulse_kind_wb", LINE_W'(is_fill), LINE_W'(e.is_fill));
        if (e.exp_cyc >= 0)
            check(is_fill ? "fill_valid_cycle" : "wb_done_cycle", LINE_W'(cyc), LINE_W'(e.exp_cyc));
        if (is_fill && e.is_fill) check("fill_line", data_to_write, e.line);
    endtask

    logic        prev_hold = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;

    always @(negedge clk) begin
        beat_t b;
        if (rst !== 1'b1) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("stall_req_held", LINE_W'(mem_req), LINE_W'(1));
                check("stall_addr_stable", LINE_W'(mem_addr), LINE_W'(prev_addr));
                check("stall_we_stable", LINE_W'(mem_we), LINE_W'(prev_we));
                check("stall_wdata_stable", LINE_W'(mem_wdata), LINE_W'(prev_wdata));
            end
            prev_hold  = mem_req && !mem_ready;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            if (mem_req && mem_ready) begin
                if (exp_beats.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: addr %0h we %0b with nothing pending (cycle %0d)",
                             mem_addr, mem_we, cyc);
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_we", LINE_W'(mem_we), LINE_W'(b.we));
                    check("beat_addr", LINE_W'(mem_addr), LINE_W'(b.addr));
                    check("beat_wdata", LINE_W'(mem_wdata), LINE_W'(b.data));
                end
            end
            if (wb_done) take_event(1'b0);
            if (fill_valid) take_event(1'b1);
        end
    end

    // Reference model: a writeback is 16 sequential word writes followed by
    // its pulse; a fill is 16 sequential reads followed by the full line.
    task automatic expect_txn(input bit do_wb, input bit do_fill, input logic [31:0] wa,
                              input logic [LINE_W-1:0] wd, input logic [31:0] fa,
                              input int req_cyc, input int delay, input bit timed);
        beat_t             b;
        event_t            e;
        logic [LINE_W-1:0] line = '0;
        int                t = req_cyc + 1;
        if (do_wb) begin
            for (int i = 0; i < BEATS; i++) begin
                b.we   = 1'b1;
                b.addr = {wa[31:6], 6'b0} + 32'(4 * i);
                b.data = wd[32*i +: 32];
                exp_beats.push_back(b);
            end
            e.is_fill = 1'b0;
            e.line    = '0;
            e.exp_cyc = timed ? t + BEATS : -1;
            exp_events.push_back(e);
            t = t + BEATS + 1;
        end
        if (do_fill) begin
            for (int i = 0; i < BEATS; i++) begin
                b.we   = 1'b0;
                b.addr = {fa[31:6], 6'b0} + 32'(4 * i);
                b.data = '0;
                exp_beats.push_back(b);
                line[32*i +: 32] = rd_val(b.addr);
            end
            e.is_fill = 1'b1;
            e.line    = line;
            e.exp_cyc = timed ? t + BEATS + delay : -1;
            exp_events.push_back(e);
            model_line = line;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_beats.size() != 0 || exp_events.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: busy %0b, %0d beats and %0d pulses still pending",
                     busy, exp_beats.size(), exp_events.size());
            exp_beats.delete();
            exp_events.delete();
        end
    endtask

    task automatic issue(input bit do_wb, input bit do_fill, input logic [31:0] wa,
                         input logic [LINE_W-1:0] wd, input logic [31:0] fa,
                         input int delay, input bit timed);
        wait_idle(600);
        wb_req       = do_wb;
        ask_for_data = do_fill;
        wb_addr      = wa;
        wb_data      = wd;
        address      = fa;
        expect_txn(do_wb, do_fill, wa, wd, fa, cyc, delay, timed);
        @(posedge clk);
        #1;
        wb_req       = 1'b0;
        ask_for_data = 1'b0;
    endtask

    task automatic complete();
        wait_idle(600);
        check("line_hold", data_to_write, model_line);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, LINE_W'(mem_req), '0);
        check({tag, "_mem_we"}, LINE_W'(mem_we), '0);
        check({tag, "_mem_addr"}, LINE_W'(mem_addr), '0);
        check({tag, "_mem_wdata"}, LINE_W'(mem_wdata), '0);
        check({tag, "_data_to_write"}, data_to_write, '0);
        check({tag, "_fill_valid"}, LINE_W'(fill_valid), '0);
        check({tag, "_wb_done"}, LINE_W'(wb_done), '0);
        check({tag, "_busy"}, LINE_W'(busy), '0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LINE_W-1:0] wd;

        rst          = 1'b0;
        ask_for_data = 1'b0;
        wb_req       = 1'b0;
        address      = '0;
        wb_addr      = '0;
        wb_data      = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Single fill with memory always ready.
        issue(1'b0, 1'b1, 32'h0, '0, 32'h0000_1234, 0, 1'b1);
        complete();
        check("fill_word0", LINE_W'(data_to_write[31:0]), LINE_W'(32'hA000_0000));
        check("fill_word15", LINE_W'(data_to_write[511:480]), LINE_W'(32'hA000_000F));

        // Writeback only: word i of the line is i; the filled line must hold.
        for (int i = 0; i < BEATS; i++) wd[32*i +: 32] = 32'(i);
        issue(1'b1, 1'b0, 32'h0000_4000, wd, 32'h0, 0, 1'b1);
        complete();

        // Writeback and fill requested together.
        for (int i = 0; i < BEATS; i++) wd[32*i +: 32] = $urandom;
        issue(1'b1, 1'b1, 32'h0000_4000, wd, 32'h0000_2040, 0, 1'b1);
        complete();

        // Three-cycle memory stall on fill beat 7.
        stall_beat = 7;
        stall_left = 3;
        issue(1'b0, 1'b1, 32'h0, '0, 32'h0001_0080, 3, 1'b1);
        complete();
        stall_beat = -1;

        // Requests pulsed while busy must be ignored.
        issue(1'b0, 1'b1, 32'h0, '0, 32'h0000_3300, 0, 1'b1);
        repeat (4) @(negedge clk);
        ask_for_data = 1'b1;
        wb_req       = 1'b1;
        address      = 32'h0000_7700;
        wb_addr      = 32'h0000_7800;
        @(negedge clk);
        ask_for_data = 1'b0;
        wb_req       = 1'b0;
        complete();

        // Reset in the middle of a fill, then a clean fill afterwards.
        issue(1'b0, 1'b1, 32'h0, '0, 32'h0000_8800, 0, 1'b0);
        for (int n = 0; n < 100; n++) begin
            if (mem_req && mem_addr[5:2] == 4'd9) break;
            @(posedge clk);
            #2;
        end
        check("reset_at_beat9", LINE_W'(mem_addr[5:2]), LINE_W'(4'd9));
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        exp_beats.delete();
        exp_events.delete();
        model_line = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_line_cleared", data_to_write, '0);
        issue(1'b0, 1'b1, 32'h0, '0, 32'h0000_9A40, 0, 1'b1);
        complete();

        // Randomized traffic with a randomly stalling memory.
        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            for (int i = 0; i < BEATS; i++) wd[32*i +: 32] = $urandom;
            rd_salt = $urandom | 32'h1;
            issue(kind != 0, kind != 1, $urandom, wd, $urandom, 0, 1'b0);
            complete();
        end

        wait_idle(600);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
